req_ack_responder: RTL and testbench

Responder end of the req/ack/valid/error handshake whose temporal properties are checked by the team's SVA implication suite. Accepts a single-cycle `req`, acknowledges it on the following cycle, then waits up to `MAX_LAT` cycles for response data from a backend source. It returns the data with `valid`, or flags `error` on timeout. It sits between a requester and a data-producing backend, and is the design-under-test that makes `req |=> ack` and `req |=> ##[1:MAX_LAT] (valid && !error)` hold whenever the backend is timely.

---
 rtl/req_ack_pkg.sv | 17 +
 rtl/sat_counter.sv | 31 +++
 rtl/req_ack_responder.sv | 106 ++++++++++
 tb/tb_req_ack_responder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/req_ack_pkg.sv
// rtl/req_ack_pkg.sv - shared types and constants for the req/ack responder
//
// Contents:
//   rsp_state_e     responder FSM state (IDLE, WAIT)
//   MAX_LAT_LIMIT   largest supported backend latency window
//   DEFAULT_DATA_W  default response data width
package req_ack_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } rsp_state_e;

  localparam int MAX_LAT_LIMIT  = 15;
  localparam int DEFAULT_DATA_W = 8;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter
//
// Ports:
//   clk    clock
//   rst_n  synchronous active-low reset
//   inc    count one event (ignored once saturated)
//   clr    synchronous clear, takes priority over inc
//   count  current count, sticks at all-ones
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      count_q <= '0;
    end else if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/req_ack_responder.sv
// rtl/req_ack_responder.sv - single-outstanding req/ack responder with backend timeout
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req                   request pulse, sampled only while idle
//   ack                   one-cycle acknowledge, the cycle after an accepted req
//   valid / error         one-cycle response / timeout strobes, mutually exclusive
//   data                  last response data, held between responses
//   busy                  request outstanding
//   src_valid, src_data   backend beat
//   src_ready             backend may transfer (same as busy)
//   err_count             saturating count of timeouts
module req_ack_responder
  import req_ack_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int MAX_LAT = 5,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  output logic              ack,
  output logic              valid,
  output logic              error,
  output logic [DATA_W-1:0] data,
  output logic              busy,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              src_ready,
  output logic [CNT_W-1:0]  err_count
);

  // Out-of-range latency settings are clamped into 1..MAX_LAT_LIMIT.
  localparam int LAT = (MAX_LAT < 1) ? 1 :
                       (MAX_LAT > MAX_LAT_LIMIT) ? MAX_LAT_LIMIT : MAX_LAT;
  localparam int CW  = $clog2(LAT + 1);

  rsp_state_e        state_q;
  logic [CW-1:0]     cnt_q;
  logic              ack_q;
  logic              valid_q;
  logic              error_q;
  logic [DATA_W-1:0] data_q;

  // Timeout fires only on the last sampling cycle, and only if the backend
  // is silent then: a beat on that same cycle still counts as a response.
  logic timeout;
  assign timeout = (state_q == WAIT) && !src_valid && (cnt_q == CW'(LAT));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        IDLE: begin
          ack_q <= 1'b0;
          if (req) begin
            state_q <= WAIT;
            ack_q   <= 1'b1;
            cnt_q   <= CW'(1);
          end
        end
        WAIT: begin
          ack_q <= 1'b0;
          if (src_valid) begin
            valid_q <= 1'b1;
            data_q  <= src_data;
            state_q <= IDLE;
          end else if (timeout) begin
            error_q <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_err_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (timeout),
    .clr  (1'b0),
    .count(err_count)
  );

  assign ack       = ack_q;
  assign valid     = valid_q;
  assign error     = error_q;
  assign data      = data_q;
  assign busy      = (state_q == WAIT);
  assign src_ready = (state_q == WAIT);

endmodule

// File: tb/tb_req_ack_responder.sv
// tb/tb_req_ack_responder.sv - self-checking bench for req_ack_responder
module tb_req_ack_responder;

  localparam int DATA_W  = 8;
  localparam int MAX_LAT = 5;
  localparam int CNT_W   = 8;

  logic              clk;
  logic              rst_n;
  logic              req;
  logic              ack;
  logic              valid;
  logic              error;
  logic [DATA_W-1:0] data;
  logic              busy;
  logic              src_valid;
  logic [DATA_W-1:0] src_data;
  logic              src_ready;
  logic [CNT_W-1:0]  err_count;

  req_ack_responder #(
    .DATA_W (DATA_W),
    .MAX_LAT(MAX_LAT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .ack      (ack),
    .valid    (valid),
    .error    (error),
    .data     (data),
    .busy     (busy),
    .src_valid(src_valid),
    .src_data (src_data),
    .src_ready(src_ready),
    .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Transaction-level model: one outstanding request, identified by the
  // cycle it was accepted in; its age selects the sampling window.
  bit              m_busy = 1'b0;
  int              t_acc  = 0;
  int              cyc    = 0;
  int              m_errcnt = 0;
  logic [DATA_W-1:0] m_data = '0;
  bit              n_ack, n_valid, n_error;

  // Expected outputs for the current cycle, published at each clock edge.
  bit              e_ack, e_valid, e_error, e_busy;
  logic [DATA_W-1:0] e_data;
  int              e_errcnt;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("ack",       int'(ack),       int'(e_ack));
      check("valid",     int'(valid),     int'(e_valid));
      check("error",     int'(error),     int'(e_error));
      check("data",      int'(data),      int'(e_data));
      check("busy",      int'(busy),      int'(e_busy));
      check("src_ready", int'(src_ready), int'(e_busy));
      check("err_count", int'(err_count), e_errcnt);
    end
  end

  task automatic step(input bit r, input bit rn, input bit sv, input logic [DATA_W-1:0] sd);
    int age;
    req = r; rst_n = rn; src_valid = sv; src_data = sd;
    n_ack = 1'b0; n_valid = 1'b0; n_error = 1'b0;
    if (!rn) begin
      m_busy = 1'b0; m_data = '0; m_errcnt = 0;
    end else if (!m_busy) begin
      if (r) begin
        m_busy = 1'b1; t_acc = cyc; n_ack = 1'b1;
      end
    end else begin
      age = cyc - t_acc;
      if (sv) begin
        n_valid = 1'b1; m_data = sd; m_busy = 1'b0;
      end else if (age == MAX_LAT) begin
        n_error = 1'b1; m_busy = 1'b0;
        if (m_errcnt < (1 << CNT_W) - 1) m_errcnt++;
      end
    end
    cyc++;
    @(posedge clk);
    e_ack = n_ack; e_valid = n_valid; e_error = n_error;
    e_busy = m_busy; e_data = m_data; e_errcnt = m_errcnt;
    #1;
  endtask

  int acks, valids;

  initial begin
    req = 1'b0; rst_n = 1'b0; src_valid = 1'b0; src_data = '0;

    // Reset for two cycles, then idle with backend noise.
    step(0, 0, 0, 8'h00);
    chk_en = 1'b1;
    step(0, 0, 1, 8'h11);
    check("rst_outputs", int'({ack, valid, error, busy, src_ready}), 0);
    check("rst_data", int'(data), 0);
    check("rst_err_count", int'(err_count), 0);
    for (int i = 0; i < 10; i++) step(0, 1, i[0], 8'(8'h30 + i));
    check("idle_busy", int'(busy), 0);
    check("idle_data", int'(data), 0);

    // Fastest response: backend ready in the first sampling cycle.
    step(1, 1, 0, 8'h00);
    check("fast_ack", int'(ack), 1);
    step(0, 1, 1, 8'hA5);
    check("fast_valid", int'(valid), 1);
    check("fast_data", int'(data), 8'hA5);
    check("fast_busy", int'(busy), 0);
    check("fast_ack_low", int'(ack), 0);

    // Backend beat outside WAIT is ignored.
    step(0, 1, 1, 8'h77);
    check("idle_src_ignored", int'(data), 8'hA5);

    // Response on the last sampling cycle (k = MAX_LAT) beats the timeout.
    step(1, 1, 0, 8'h00);
    for (int i = 0; i < MAX_LAT - 1; i++) step(1, 1, 0, 8'h00);
    step(0, 1, 1, 8'h3C);
    check("late_valid", int'(valid), 1);
    check("late_error", int'(error), 0);
    check("late_data", int'(data), 8'h3C);

    // Timeouts: first one pinned, then drive to saturation.
    for (int n = 0; n < 256; n++) begin
      step(1, 1, 0, 8'h00);
      for (int i = 0; i < MAX_LAT; i++) step(0, 1, 0, 8'h00);
      if (n == 0) begin
        check("to_error", int'(error), 1);
        check("to_valid", int'(valid), 0);
        check("to_err_count1", int'(err_count), 1);
        check("to_data_held", int'(data), 8'h3C);
      end
    end
    check("to_err_count_sat", int'(err_count), 255);
    step(0, 1, 0, 8'h00);

    // req held high with backend always ready: ack every other cycle.
    acks = 0; valids = 0;
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 1, 8'(8'hC0 + i));
      acks += int'(ack);
      valids += int'(valid);
    end
    check("held_acks", acks, 3);
    check("held_valids", valids, 3);
    step(0, 1, 0, 8'h00);
    step(0, 1, 0, 8'h00);

    // Reset mid-transaction with a backend beat in the same cycle.
    step(1, 1, 0, 8'h00);
    step(0, 1, 0, 8'h00);
    step(0, 1, 0, 8'h00);
    step(0, 0, 1, 8'h5A);
    check("abort_valid", int'(valid), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_data", int'(data), 0);
    check("abort_err_count", int'(err_count), 0);
    step(0, 1, 1, 8'h5A);
    check("abort_idle_after", int'({valid, error, busy}), 0);
    step(0, 1, 0, 8'h00);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
